// File: rtl/ss_pkg.sv
// Shared definitions for the seven-segment scan path: segment bit positions and hex glyph table.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package ss_pkg;

   // Segment bit positions within a seg_t (active-high inside the design)
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   typedef logic [7:0] seg_t;

   // Hex glyphs 0-F, bit0=A .. bit6=G, 1 = segment lit
   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
      7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
      7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
      7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
   };

endpackage

// File: rtl/hex_seg_decode.sv
// Hex nibble to active-high A-G segment pattern, table-driven from ss_pkg.
// Latency: purely combinational.
// Backpressure: none.
module hex_seg_decode
   import ss_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = GLYPH[i_nibble];

endmodule

// File: rtl/ss_scan_mux.sv
// Time-multiplexed scan controller for an N-digit seven-segment display with leading-zero blanking.
// Latency: seg/an registered one cycle after the refresh counter and digit index; load visible next cycle.
// Backpressure: none; load is a capture strobe, the scan free-runs.
module ss_scan_mux
   import ss_pkg::*;
#(
   parameter  int NUM_DIGITS     = 4,
   parameter  int REFRESH_DIV    = 100000,
   parameter  int BLANK_CYCLES   = 16,
   parameter  int SEG_ACTIVE_LOW = 1,
   parameter  int AN_ACTIVE_LOW  = 1,
   localparam int IDX_W          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [IDX_W-1:0]        digit_idx,
   output logic                    slot_start
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam seg_t SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] AN_INV = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

   // Shadow copies of the displayed data
   logic [4*NUM_DIGITS-1:0] r_value;
   logic [NUM_DIGITS-1:0]   r_dp;
   logic                    r_blz;

   // Scan state
   logic [CNT_W-1:0]        r_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic                    r_slot_start;

   // Registered outputs, active-high internally
   seg_t                    r_seg;
   logic [NUM_DIGITS-1:0]   r_an;

   logic                    w_wrap;
   logic [IDX_W-1:0]        w_idx_next;
   logic [3:0]              w_nibble;
   logic [6:0]              w_glyph;
   logic [NUM_DIGITS-1:0]   w_zero_above;
   logic                    w_blank_digit;
   logic                    w_in_blank;
   logic [NUM_DIGITS-1:0]   w_an_onehot;
   seg_t                    w_seg_next;

   assign w_wrap      = (r_cnt == CNT_LAST);
   assign w_idx_next  = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
   assign w_nibble    = r_value[4*int'(r_idx) +: 4];
   assign w_in_blank  = (r_cnt < CNT_BLANK);
   assign w_an_onehot = NUM_DIGITS'(1) << r_idx;

   // w_zero_above[i] is set when every nibble from the top digit down to i is zero
   always_comb begin
      logic v_run;
      v_run        = 1'b1;
      w_zero_above = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         v_run           = v_run & (r_value[4*i +: 4] == 4'h0);
         w_zero_above[i] = v_run;
      end
   end

   // Digit 0 is never blanked so a zero value still shows a single 0
   assign w_blank_digit = r_blz && (r_idx != '0) && w_zero_above[r_idx];

   hex_seg_decode u_decode (
      .i_nibble (w_nibble),
      .o_seg    (w_glyph)
   );

   // Segment pattern for the digit currently scanned; dp survives blanking
   always_comb begin
      w_seg_next               = '0;
      w_seg_next[SEG_G:SEG_A]  = w_blank_digit ? 7'h00 : w_glyph;
      w_seg_next[SEG_DP]       = r_dp[r_idx];
   end

   // Capture shadow data on the load strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_value <= '0;
         r_dp    <= '0;
         r_blz   <= 1'b0;
      end else if (load) begin
         r_value <= value;
         r_dp    <= dp_in;
         r_blz   <= blank_lz;
      end
   end

   // Refresh counter and digit index, with a slot-start pulse on each advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= '0;
         r_idx        <= '0;
         r_slot_start <= 1'b0;
      end else begin
         r_slot_start <= w_wrap;
         if (w_wrap) begin
            r_cnt <= '0;
            r_idx <= w_idx_next;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Output stage: everything dark during the anti-ghosting window at slot start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an  <= '0;
         r_seg <= '0;
      end else if (w_in_blank) begin
         r_an  <= '0;
         r_seg <= '0;
      end else begin
         r_an  <= w_an_onehot;
         r_seg <= w_seg_next;
      end
   end

   // Pin polarity applied last on registered values only
   assign seg        = r_seg ^ SEG_INV;
   assign an         = r_an ^ AN_INV;
   assign digit_idx  = r_idx;
   assign slot_start = r_slot_start;

endmodule
